corevx_icache: RTL and testbench

- Direct-mapped, read-only instruction cache sitting directly upstream of corevx_fetch.
- Accepts EXECUTE and FLUSH_ALL commands on the fetch-side cache interface and returns registered response codes plus instruction data.
- Refills lines from a single-word request/acknowledge memory port.
- No MMU in this block: PAGEFAULT is never produced.

---
 rtl/corevx_cache_pkg.sv | 29 ++
 rtl/corevx_mem_1rw.sv | 34 +++
 rtl/corevx_icache.sv | 209 ++++++++++++++++++++
 tb/tb_corevx_icache.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_cache_pkg.sv
// Shared command/response codes, address-field widths and the icache state
// type used by the CoreVX cache blocks.
package corevx_cache_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BYTE_W       = 2;
  localparam int DEF_LANES_W  = 6;
  localparam int DEF_OFFSET_W = 2;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd2;

  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_WAIT        = 4'd1;
  localparam logic [3:0] RESP_DONE        = 4'd2;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd4;
  localparam logic [3:0] RESP_PAGEFAULT   = 4'd5;

  typedef enum logic [1:0] {
    ST_INVAL,
    ST_IDLE,
    ST_REFILL,
    ST_FLUSH
  } icache_state_e;

endpackage

// File: rtl/corevx_mem_1rw.sv
// Synchronous single-port RAM; the read register only updates on a read
// access, so its output holds between reads.
module corevx_mem_1rw #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/corevx_icache.sv
// Direct-mapped read-only instruction cache in front of corevx_fetch, refilling
// whole lines one word at a time from a request/acknowledge memory port.
module corevx_icache
  import corevx_cache_pkg::*;
#(
  parameter int LANES_W  = DEF_LANES_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        c_reset_done,
  output logic        m_transaction,
  output logic [31:0] m_address,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_rresp
);

  localparam int TAG_W  = ADDR_W - BYTE_W - LANES_W - OFFSET_W;
  localparam int LINES  = 2 ** LANES_W;
  localparam int MEM_AW = LANES_W + OFFSET_W;

  icache_state_e state, state_n;

  logic [LANES_W-1:0]  idx_cnt, idx_cnt_n;
  logic [OFFSET_W-1:0] word_cnt, word_cnt_n;
  logic [TAG_W-1:0]    refill_tag, refill_tag_n;
  logic [LANES_W-1:0]  refill_idx, refill_idx_n;
  logic [3:0]          resp_n;
  logic                mtx_n;
  logic [31:0]         maddr_n;

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tag_arr [0:LINES-1];
  logic                valid_clr, valid_set;
  logic [LANES_W-1:0]  valid_idx;

  logic                mem_en, mem_we;
  logic [MEM_AW-1:0]   mem_addr;

  logic [TAG_W-1:0]    req_tag;
  logic [LANES_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic                hit, beat;

  assign req_tag  = c_address[ADDR_W-1 -: TAG_W];
  assign req_idx  = c_address[BYTE_W+OFFSET_W +: LANES_W];
  assign req_word = c_address[BYTE_W +: OFFSET_W];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign beat     = m_transaction && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INVAL;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    resp_n       = c_response;
    idx_cnt_n    = idx_cnt;
    word_cnt_n   = word_cnt;
    refill_tag_n = refill_tag;
    refill_idx_n = refill_idx;
    mtx_n        = m_transaction;
    maddr_n      = m_address;
    valid_clr    = 1'b0;
    valid_set    = 1'b0;
    valid_idx    = idx_cnt;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {req_idx, req_word};

    case (state)
      ST_INVAL: begin
        valid_clr = 1'b1;
        resp_n    = RESP_IDLE;
        idx_cnt_n = idx_cnt + 1'b1;
        if (&idx_cnt) begin
          state_n = ST_IDLE;
        end
      end

      ST_IDLE: begin
        resp_n = RESP_IDLE;
        if (c_cmd == CMD_EXECUTE) begin
          if (c_address[BYTE_W-1:0] != '0) begin
            resp_n = RESP_MISSALIGNED;
          end else if (hit) begin
            resp_n = RESP_DONE;
            mem_en = 1'b1;
          end else begin
            resp_n       = RESP_WAIT;
            refill_tag_n = req_tag;
            refill_idx_n = req_idx;
            word_cnt_n   = '0;
            mtx_n        = 1'b1;
            maddr_n      = {req_tag, req_idx, {OFFSET_W{1'b0}}, 2'b00};
            state_n      = ST_REFILL;
          end
        end else if (c_cmd == CMD_FLUSH_ALL) begin
          resp_n    = RESP_WAIT;
          idx_cnt_n = '0;
          state_n   = ST_FLUSH;
        end
      end

      ST_REFILL: begin
        resp_n   = RESP_WAIT;
        mem_addr = {refill_idx, word_cnt};
        if (beat) begin
          if (m_rresp) begin
            // The partially rewritten line must never be reported as a hit.
            resp_n    = RESP_ACCESSFAULT;
            mtx_n     = 1'b0;
            valid_clr = 1'b1;
            valid_idx = refill_idx;
            state_n   = ST_IDLE;
          end else begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            if (&word_cnt) begin
              valid_set = 1'b1;
              valid_idx = refill_idx;
              mtx_n     = 1'b0;
              state_n   = ST_IDLE;
            end else begin
              word_cnt_n = word_cnt + 1'b1;
              maddr_n    = {refill_tag, refill_idx, word_cnt_n, 2'b00};
            end
          end
        end
      end

      ST_FLUSH: begin
        valid_clr = 1'b1;
        resp_n    = RESP_WAIT;
        idx_cnt_n = idx_cnt + 1'b1;
        if (&idx_cnt) begin
          resp_n  = RESP_DONE;
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_INVAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_response    <= RESP_IDLE;
      c_reset_done  <= 1'b0;
      m_transaction <= 1'b0;
      m_address     <= '0;
      idx_cnt       <= '0;
      word_cnt      <= '0;
      refill_tag    <= '0;
      refill_idx    <= '0;
    end else begin
      c_response    <= resp_n;
      m_transaction <= mtx_n;
      m_address     <= maddr_n;
      idx_cnt       <= idx_cnt_n;
      word_cnt      <= word_cnt_n;
      refill_tag    <= refill_tag_n;
      refill_idx    <= refill_idx_n;
      if (state == ST_IDLE) begin
        c_reset_done <= 1'b1;
      end
    end
  end

  // Valid bits are cleared by the INVAL sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (valid_clr) begin
      valid[valid_idx] <= 1'b0;
    end else if (valid_set) begin
      valid[valid_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_set) begin
      tag_arr[refill_idx] <= refill_tag;
    end
  end

  corevx_mem_1rw #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (m_rdata),
    .rdata (c_load_data)
  );

endmodule

// File: tb/tb_corevx_icache.sv
// Randomized self-checking bench for corevx_icache against a line-level
// behavioural cache model and a deterministic backing memory.
module tb_corevx_icache;

  localparam int LINES = 64;
  localparam int WORDS = 4;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_EXEC  = 4'd1;
  localparam logic [3:0] C_FLUSH = 4'd2;

  localparam logic [3:0] R_IDLE = 4'd0;
  localparam logic [3:0] R_WAIT = 4'd1;
  localparam logic [3:0] R_DONE = 4'd2;
  localparam logic [3:0] R_AF   = 4'd3;
  localparam logic [3:0] R_MIS  = 4'd4;

  localparam int M_INIT   = 0;
  localparam int M_IDLE   = 1;
  localparam int M_REFILL = 2;
  localparam int M_FLUSH  = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  logic        m_transaction;
  logic [31:0] m_address;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_rresp;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          mode;
  int          sweep;
  bit          lineValid [LINES];
  logic [21:0] lineTag [LINES];
  logic [31:0] lineData [LINES][WORDS];
  logic [31:0] fillBuf [WORDS];
  logic [21:0] missTag;
  int          missIdx;
  int          missWord;
  logic [31:0] missBase;
  logic [3:0]  expResp;
  logic [31:0] expData;
  logic        expDone;
  logic        expMtx;
  logic [31:0] expMaddr;

  // Memory responder policy
  int          readyMode = 0;
  int          gapCnt = 0;
  int          errWord = -1;
  bit          errRandom = 0;
  logic [31:0] beatAddrs [$];

  corevx_icache dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c_cmd         (c_cmd),
    .c_address     (c_address),
    .c_response    (c_response),
    .c_load_data   (c_load_data),
    .c_reset_done  (c_reset_done),
    .m_transaction (m_transaction),
    .m_address     (m_address),
    .m_ready       (m_ready),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[31:4] == 28'h0000200) begin
      case (a[3:2])
        2'd0:    return 32'h0000_0013;
        2'd1:    return 32'h0000_0001;
        2'd2:    return 32'h0000_0002;
        default: return 32'h0000_0003;
      endcase
    end
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predicts the cache's observable state after one clock edge.
  task automatic modelEdge(input logic [3:0] cmd, input logic [31:0] addr, input bit rstLow,
                           input bit rdy, input logic [31:0] rdata, input bit rresp);
    bit          wasIdle;
    int          idx;
    int          wd;
    logic [21:0] tag;
    if (rstLow) begin
      mode = M_INIT; sweep = 0;
      expResp = R_IDLE; expData = '0; expDone = 1'b0; expMtx = 1'b0; expMaddr = '0;
      return;
    end
    wasIdle = (mode == M_IDLE);
    case (mode)
      M_INIT: begin
        lineValid[sweep] = 1'b0;
        sweep++;
        expResp = R_IDLE;
        if (sweep == LINES) mode = M_IDLE;
      end
      M_IDLE: begin
        expResp = R_IDLE;
        idx = int'((addr >> 4) % LINES);
        wd  = int'((addr >> 2) % WORDS);
        tag = addr[31:10];
        if (cmd == C_EXEC) begin
          if (addr % 4 != 0) begin
            expResp = R_MIS;
          end else if (lineValid[idx] && lineTag[idx] == tag) begin
            expResp = R_DONE;
            expData = lineData[idx][wd];
          end else begin
            expResp = R_WAIT;
            lineValid[idx] = 1'b0;
            missTag = tag; missIdx = idx; missWord = 0;
            missBase = addr & ~32'hF;
            expMtx = 1'b1; expMaddr = missBase;
            mode = M_REFILL;
          end
        end else if (cmd == C_FLUSH) begin
          expResp = R_WAIT; sweep = 0; mode = M_FLUSH;
        end
      end
      M_REFILL: begin
        expResp = R_WAIT;
        if (expMtx && rdy) begin
          if (rresp) begin
            expResp = R_AF; expMtx = 1'b0; mode = M_IDLE;
          end else begin
            fillBuf[missWord] = rdata;
            missWord++;
            if (missWord == WORDS) begin
              for (int w = 0; w < WORDS; w++) lineData[missIdx][w] = fillBuf[w];
              lineTag[missIdx] = missTag;
              lineValid[missIdx] = 1'b1;
              expMtx = 1'b0; mode = M_IDLE;
            end else begin
              expMaddr = missBase + 32'(4 * missWord);
            end
          end
        end
      end
      default: begin
        lineValid[sweep] = 1'b0;
        sweep++;
        expResp = (sweep == LINES) ? R_DONE : R_WAIT;
        if (sweep == LINES) mode = M_IDLE;
      end
    endcase
    if (wasIdle) expDone = 1'b1;
  endtask

  // One clock cycle: drive fetch/memory inputs, advance the model, compare.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] addr, input bit rstLow);
    bit          rdy;
    bit          rresp;
    logic [31:0] rdata;
    rdy = 1'b0; rresp = 1'b0; rdata = $urandom;
    if (expMtx) begin
      if (readyMode == 0) rdy = (gapCnt == 1);
      else rdy = ($urandom_range(0, 2) == 0);
      if (rdy) begin
        rdata = memval(expMaddr);
        if (errWord == int'(expMaddr[3:2])) begin
          rresp = 1'b1; errWord = -1;
        end else if (errRandom && $urandom_range(0, 9) == 0) begin
          rresp = 1'b1;
        end
      end
      gapCnt = rdy ? 0 : gapCnt + 1;
    end else begin
      gapCnt = 0;
      if (readyMode == 1) rdy = ($urandom_range(0, 3) == 0);
      rresp = $urandom_range(0, 1) == 1;
    end
    rst_n = !rstLow; c_cmd = cmd; c_address = addr;
    m_ready = rdy; m_rdata = rdata; m_rresp = rresp;
    if (rdy && m_transaction) beatAddrs.push_back(m_address);
    modelEdge(cmd, addr, rstLow, rdy, rdata, rresp);
    @(posedge clk);
    #1;
    checkOutput("resp", 32'(c_response), 32'(expResp));
    checkOutput("data", c_load_data, expData);
    checkOutput("reset_done", 32'(c_reset_done), 32'(expDone));
    checkOutput("m_transaction", 32'(m_transaction), 32'(expMtx));
    checkOutput("m_address", m_address, expMaddr);
  endtask

  // Re-drives one EXECUTE until the response leaves WAIT, with a cycle budget.
  task automatic waitResponse(input logic [31:0] addr, input string tag);
    int n;
    n = 0;
    applyStimulus(C_EXEC, addr, 1'b0);
    while (c_response == R_WAIT && n < 60) begin
      n++;
      applyStimulus(C_EXEC, addr, 1'b0);
    end
    checkOutput({tag, "_bound"}, 32'(n < 60), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int          n;
    int          waits;
    logic [31:0] a;
    int          r;
    logic [3:0]  cmd;

    rst_n = 1'b0; c_cmd = C_NONE; c_address = '0;
    m_ready = 1'b0; m_rdata = '0; m_rresp = 1'b0;
    expMtx = 1'b0; expMaddr = '0;

    for (int i = 0; i < 3; i++) applyStimulus(C_NONE, 32'h0, 1'b1);

    $display("[TB] reset release and invalidation sweep");
    n = 0;
    do begin
      applyStimulus((n < 60) ? C_EXEC : C_NONE, 32'h2000, 1'b0);
      n++;
    end while (!c_reset_done && n < 100);
    checkOutput("reset_done_latency", 32'(n), 32'd65);

    $display("[TB] cold miss on 0x2000");
    beatAddrs.delete();
    readyMode = 0;
    waitResponse(32'h2000, "fill_2000");
    checkOutput("fill_resp", 32'(c_response), 32'(R_DONE));
    checkOutput("fill_data", c_load_data, 32'h13);
    checkOutput("fill_beats", 32'(beatAddrs.size()), 32'd4);
    for (int i = 0; i < beatAddrs.size() && i < 4; i++)
      checkOutput("fill_addr", beatAddrs[i], 32'h2000 + 32'(4 * i));

    $display("[TB] back-to-back hits");
    for (int i = 1; i < 4; i++) begin
      applyStimulus(C_EXEC, 32'h2000 + 32'(4 * i), 1'b0);
      checkOutput("hit_resp", 32'(c_response), 32'(R_DONE));
      checkOutput("hit_data", c_load_data, 32'(i));
      checkOutput("hit_no_mem", 32'(m_transaction), 32'd0);
    end

    applyStimulus(C_EXEC, 32'h2002, 1'b0);
    checkOutput("misaligned", 32'(c_response), 32'(R_MIS));
    checkOutput("misaligned_no_mem", 32'(m_transaction), 32'd0);

    $display("[TB] refill aborted by memory error");
    errWord = 1;
    waitResponse(32'h3000, "fault_3000");
    checkOutput("fault_resp", 32'(c_response), 32'(R_AF));
    applyStimulus(C_EXEC, 32'h3000, 1'b0);
    checkOutput("refetch_miss", 32'(c_response), 32'(R_WAIT));
    checkOutput("refetch_addr", m_address, 32'h3000);
    waitResponse(32'h3000, "refetch_3000");
    checkOutput("refetch_data", c_load_data, memval(32'h3000));

    $display("[TB] flush all");
    waits = 0;
    applyStimulus(C_FLUSH, 32'h0, 1'b0);
    while (c_response == R_WAIT && waits < 100) begin
      waits++;
      applyStimulus(C_FLUSH, 32'h0, 1'b0);
    end
    checkOutput("flush_waits", 32'(waits), 32'd64);
    checkOutput("flush_done", 32'(c_response), 32'(R_DONE));
    applyStimulus(C_NONE, 32'h0, 1'b0);
    checkOutput("flush_done_once", 32'(c_response), 32'(R_IDLE));
    applyStimulus(C_EXEC, 32'h2000, 1'b0);
    checkOutput("post_flush_miss", 32'(c_response), 32'(R_WAIT));
    checkOutput("post_flush_addr", m_address, 32'h2000);
    waitResponse(32'h2000, "post_flush");

    $display("[TB] reset during refill");
    applyStimulus(C_EXEC, 32'h5000, 1'b0);
    applyStimulus(C_NONE, 32'h0, 1'b1);
    checkOutput("reset_drops_req", 32'(m_transaction), 32'd0);
    for (int i = 0; i < 66; i++) applyStimulus(C_NONE, 32'h0, 1'b0);

    $display("[TB] randomized traffic");
    readyMode = 1;
    errRandom = 1;
    for (int i = 0; i < 700; i++) begin
      a = (32'($urandom_range(0, 3)) << 10);
      r = $urandom_range(0, 3);
      a = a | (32'((r == 3) ? 63 : r) << 4) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
      r = $urandom_range(0, 19);
      if (r < 14) cmd = C_EXEC;
      else if (r == 14) cmd = C_FLUSH;
      else if (r < 17) cmd = 4'($urandom_range(3, 15));
      else cmd = C_NONE;
      applyStimulus(cmd, a, (i == 350 || i == 351));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
